// File: rtl/mode_counter.sv
// mode_counter: up/down event/timebase counter with programmable bounds,
// step size and prescaler. Wraps to the opposite bound or saturates at the
// bound. Reports boundary events and processed ticks as one-cycle
// registered pulses.
module mode_counter #(
    parameter int WIDTH          = 8,
    parameter int MIN_COUNT      = 0,
    parameter int MAX_COUNT      = 255,
    parameter int STEP_WIDTH     = 4,
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      load,
    input  logic [WIDTH-1:0]          load_value,
    input  logic                      dir,
    input  logic                      saturate,
    input  logic [STEP_WIDTH-1:0]     step,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic [WIDTH-1:0]          count,
    output logic                      overflow,
    output logic                      underflow,
    output logic                      tick,
    output logic                      terminal
);

    // Sum width is wide enough that count +/- step never wraps, and the
    // extra top bit keeps a down-count below zero negative.
    localparam int SW = WIDTH + STEP_WIDTH + 1;

    localparam logic [WIDTH-1:0]     MIN_V = WIDTH'(MIN_COUNT);
    localparam logic [WIDTH-1:0]     MAX_V = WIDTH'(MAX_COUNT);
    localparam logic signed [SW-1:0] MIN_S = SW'(MIN_COUNT);
    localparam logic signed [SW-1:0] MAX_S = SW'(MAX_COUNT);

    logic [PRESCALE_WIDTH-1:0] pre_cnt;
    logic [PRESCALE_WIDTH-1:0] next_pre;
    logic [WIDTH-1:0]          next_count;
    logic                      next_overflow;
    logic                      next_underflow;
    logic                      next_tick;

    logic signed [SW-1:0] count_ext;
    logic signed [SW-1:0] step_ext;
    logic signed [SW-1:0] load_ext;
    logic signed [SW-1:0] sum;
    logic                 pre_hit;

    // Next-state logic: load beats enable; a prescaler tick applies the step
    // and resolves wrap/saturate at the bounds.
    always_comb begin
        count_ext      = $signed({{(STEP_WIDTH + 1){1'b0}}, count});
        step_ext       = $signed({{(WIDTH + 1){1'b0}}, step});
        load_ext       = $signed({{(STEP_WIDTH + 1){1'b0}}, load_value});
        sum            = dir ? (count_ext + step_ext) : (count_ext - step_ext);
        // >= rather than == so a prescale value shrunk below pre_cnt still
        // produces a tick instead of running pre_cnt all the way around.
        pre_hit        = (pre_cnt >= prescale);

        next_count     = count;
        next_pre       = pre_cnt;
        next_overflow  = 1'b0;
        next_underflow = 1'b0;
        next_tick      = 1'b0;

        if (load) begin
            next_pre = '0;
            if (load_ext < MIN_S) begin
                next_count = MIN_V;
            end else if (load_ext > MAX_S) begin
                next_count = MAX_V;
            end else begin
                next_count = load_value;
            end
        end else if (enable) begin
            if (pre_hit) begin
                next_pre  = '0;
                next_tick = 1'b1;
                if (dir && (sum > MAX_S)) begin
                    next_overflow = 1'b1;
                    next_count    = saturate ? MAX_V : MIN_V;
                end else if (!dir && (sum < MIN_S)) begin
                    next_underflow = 1'b1;
                    next_count     = saturate ? MIN_V : MAX_V;
                end else begin
                    next_count = sum[WIDTH-1:0];
                end
            end else begin
                next_pre = pre_cnt + PRESCALE_WIDTH'(1);
            end
        end
    end

    // State register; reset discards any pending prescale or pulse state.
    always_ff @(posedge clk) begin
        if (reset) begin
            count     <= MIN_V;
            pre_cnt   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            tick      <= 1'b0;
        end else begin
            count     <= next_count;
            pre_cnt   <= next_pre;
            overflow  <= next_overflow;
            underflow <= next_underflow;
            tick      <= next_tick;
        end
    end

    // Terminal flags the bound the counter is currently heading toward.
    assign terminal = dir ? (count == MAX_V) : (count == MIN_V);

endmodule

// File: doc/mode_counter.md
# mode_counter

Parametrised up/down counter with programmable bounds, step size, prescaler, and wrap or saturate mode. It generalises the basic 8-bit wrap-to-zero counter and is the standard event/timebase counter for testbench DUT examples and peripheral timers. Boundary events are reported as registered one-cycle overflow/underflow pulses.

## Interface
- `WIDTH`, default 8: count width; legal range 2..32.
- `MIN_COUNT`, default 0: lower bound; requires 0 ≤ MIN_COUNT < MAX_COUNT.
- `MAX_COUNT`, default 255: upper bound; requires MAX_COUNT ≤ 2^WIDTH−1.
- `STEP_WIDTH`, default 4: width of `step`.
- `PRESCALE_WIDTH`, default 8: width of `prescale`.

Ports:
- `clk`  in  1  the single clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high; highest priority.
- `enable`  in  1  advances the prescaler; count moves only on a prescaler tick.
- `load`  in  1  loads the clamped `load_value`; priority over `enable`.
- `load_value`  in  WIDTH  value to load.
- `dir`  in  1  1 = count up, 0 = count down.
- `saturate`  in  1  1 = clamp at the bound, 0 = wrap to the opposite bound.
- `step`  in  STEP_WIDTH  increment per tick; 0 means hold.
- `prescale`  in  PRESCALE_WIDTH  a tick occurs every `prescale`+1 enabled cycles.
- `count`  out  WIDTH  registered count, always within [MIN_COUNT, MAX_COUNT].
- `overflow`  out  1  registered pulse on an up-boundary event.
- `underflow`  out  1  registered pulse on a down-boundary event.
- `tick`  out  1  registered pulse when a prescaler tick was processed.
- `terminal`  out  1  combinational: (dir ? count==MAX_COUNT : count==MIN_COUNT).

## Operation
- Priority on each edge: reset > load > enable > hold.
- Reset:
  - count ← MIN_COUNT; overflow, underflow, tick ← 0.
  - Internal prescaler counter `pre_cnt` ← 0.
  - `terminal` follows `count` and `dir`. After reset with dir=0 it reads 1; with dir=1 it reads 0.
- Load:
  - count ← clamp(load_value, MIN_COUNT, MAX_COUNT).
  - pre_cnt ← 0; overflow, underflow, tick ← 0.
- Prescaler:
  - It advances only when enable=1 and load=0.
  - If pre_cnt ≥ prescale, a tick occurs and pre_cnt ← 0; otherwise pre_cnt ← pre_cnt+1.
  - The ≥ compare keeps the prescaler from locking up when `prescale` shrinks mid-count.
  - With enable=0, pre_cnt holds.
- On a tick, sum = count ± step, computed at WIDTH+STEP_WIDTH+1 bits signed, so no intermediate wrap.
  - Up, sum > MAX_COUNT: wrap mode → count ← MIN_COUNT; saturate mode → count ← MAX_COUNT. overflow ← 1 in both modes.
  - Down, sum < MIN_COUNT: wrap mode → count ← MAX_COUNT; saturate mode → count ← MIN_COUNT. underflow ← 1 in both modes.
  - Otherwise count ← sum.
  - A boundary event is any tick whose sum leaves the range. This includes every tick while already clamped at the bound in saturate mode.
  - tick ← 1 on a tick, including when step=0.
  - step=0: count holds, no boundary flag.
- On non-tick cycles, overflow, underflow and tick ← 0, so each is a single-cycle pulse.
- `dir`, `saturate`, `step` and `prescale` are sampled on the edge where they are used. Changing them between ticks is legal.

## Timing
- Latency, prescale=0: count changes on the first edge with enable=1.
- Latency, prescale=N: count changes on the (N+1)-th enabled edge after reset or load, then every N+1 enabled edges.
- overflow, underflow and tick assert in the same cycle that `count` shows the post-tick value. They deassert on the next edge unless another event occurs.
- Load and reset take effect on the edge where they are sampled high. The new count is visible in the following cycle.
- Reset mid-prescale or mid-boundary discards pending state. No pulse is emitted after reset.

## Test plan
All scenarios use WIDTH=8, MIN_COUNT=10, MAX_COUNT=200.
1. Wrap up: reset, dir=1, step=1, prescale=0, saturate=0, enable held for 192 cycles -> count goes 10…200, then 10. overflow is high exactly one cycle, coincident with count=10. terminal=1 while count=200.
2. Saturate down: load 12; then dir=0, step=5, saturate=1, enable held 3 cycles -> count 10, 10, 10; underflow pulses on all 3 ticks; terminal=1.
3. Prescaler: prescale=3, step=2, up from 10 -> count 12 on the 4th enabled edge and 14 on the 8th. enable low for 5 cycles mid-interval -> pre_cnt and count hold. Changing prescale from 3 to 0 while pre_cnt=2 -> tick on the next enabled edge.
4. Load clamp/priority: load_value=250 -> count 200. load_value=3 -> count 10. load=1 with enable=1 and load_value=50 -> count 50, no tick, pre_cnt cleared.
5. Reset mid-operation: count=150, pre_cnt=2, reset with load=1 and enable=1 on the same edge -> count 10, all pulses 0. The next tick needs a full prescale+1 enabled cycles.
6. Wrap down and zero step: dir=0, step=15 from 20 -> count 200 with underflow pulse. Then step=0 for 4 ticks -> count stays 200, tick pulses, no flags.
